// File: rtl/seg_scan_if.sv
// rtl/seg_scan_if.sv - control/display signal bundle between scan controller and display side
interface seg_scan_if #(
  parameter int NUM_DIG = 6
);
  logic               en;
  logic               lz_en;
  logic [2:0]         dp_pos;
  logic [3:0]         bcd_in;
  logic [3:0]         sel;
  logic [NUM_DIG-1:0] an;
  logic [6:0]         seg;
  logic               dp;
  logic               frame_tick;

  modport master (
    output en, lz_en, dp_pos, bcd_in,
    input  sel, an, seg, dp, frame_tick
  );

  modport slave (
    input  en, lz_en, dp_pos, bcd_in,
    output sel, an, seg, dp, frame_tick
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - 6-digit 7-segment scan controller with blanking gap,
// leading-zero suppression and per-frame tick
module seg_scan_ctrl #(
  parameter int CLK_DIV   = 50000,
  parameter int BLANK_CYC = 500,
  parameter int NUM_DIG   = 6
) (
  input  logic      clk,
  input  logic      rst_n,
  seg_scan_if.slave bus
);
  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [3:0]    LAST_SEL = 4'(NUM_DIG - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYC - 1);
  localparam logic [CW-1:0] SLOT_END  = CW'(CLK_DIV - 1);

  typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

  state_t             r_state;
  logic [CW-1:0]      r_cnt;
  logic [3:0]         r_sel;
  logic [NUM_DIG-1:0] r_an;
  logic [6:0]         r_seg;
  logic               r_dp;
  logic               r_tick;
  logic               r_lz;

  logic       w_digit_nz;
  logic       w_suppress;
  logic       w_dp_hit;
  logic [6:0] w_pattern;

  function automatic logic [6:0] decode(input logic [3:0] v);
    case (v)
      4'd0:    decode = 7'h40;
      4'd1:    decode = 7'h79;
      4'd2:    decode = 7'h24;
      4'd3:    decode = 7'h30;
      4'd4:    decode = 7'h19;
      4'd5:    decode = 7'h12;
      4'd6:    decode = 7'h02;
      4'd7:    decode = 7'h78;
      4'd8:    decode = 7'h00;
      4'd9:    decode = 7'h10;
      default: decode = 7'h7F;
    endcase
  endfunction

  // lz flag stays set only while every digit so far in the frame was zero or non-decimal
  assign w_digit_nz = (bus.bcd_in != 4'd0) && (bus.bcd_in <= 4'd9);
  assign w_suppress = bus.lz_en && r_lz && (bus.bcd_in == 4'd0) && (r_sel != 4'd0);
  assign w_dp_hit   = ({1'b0, bus.dp_pos} == r_sel);
  assign w_pattern  = w_suppress ? 7'h7F : decode(bus.bcd_in);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_sel   <= LAST_SEL;
      r_an    <= '1;
      r_seg   <= 7'h7F;
      r_dp    <= 1'b1;
      r_tick  <= 1'b0;
      r_lz    <= 1'b1;
    end else begin
      r_tick <= 1'b0;
      if (!bus.en) begin
        r_state <= IDLE;
        r_cnt   <= '0;
        r_sel   <= LAST_SEL;
        r_an    <= '1;
        r_seg   <= 7'h7F;
        r_dp    <= 1'b1;
        r_lz    <= 1'b1;
      end else begin
        case (r_state)
          IDLE: begin
            r_state <= BLANK;
            r_cnt   <= '0;
            r_sel   <= LAST_SEL;
            r_lz    <= 1'b1;
          end
          BLANK: begin
            r_cnt <= r_cnt + CW'(1);
            // segments and the anode switch on together so no stale pattern is ever lit
            if (r_cnt == BLANK_END) begin
              r_seg   <= w_pattern;
              r_dp    <= ~w_dp_hit;
              r_an    <= ~(NUM_DIG'(1) << r_sel);
              r_state <= SHOW;
              if (w_digit_nz) begin
                r_lz <= 1'b0;
              end
            end
          end
          SHOW: begin
            if (r_cnt == SLOT_END) begin
              r_cnt   <= '0;
              r_an    <= '1;
              r_state <= BLANK;
              if (r_sel == 4'd0) begin
                r_sel  <= LAST_SEL;
                r_lz   <= 1'b1;
                r_tick <= 1'b1;
              end else begin
                r_sel <= r_sel - 4'd1;
              end
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign bus.sel        = r_sel;
  assign bus.an         = r_an;
  assign bus.seg        = r_seg;
  assign bus.dp         = r_dp;
  assign bus.frame_tick = r_tick;
endmodule
